// File: rtl/button_conditioner.sv
// Debounces the five Basys3 push-buttons and turns them into press/release pulses.
// The up/down channels also generate auto-repeat pulses while the button is held.
// release/repeat are SystemVerilog keywords, so those outputs carry a _pulse suffix.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 30_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic [4:0] level,
  output logic [4:0] press,
  output logic [4:0] release_pulse,
  output logic [1:0] repeat_pulse
);

  localparam int unsigned NumBtn = 5;
  localparam int unsigned NumRpt = 2;
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax);

  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } rpt_state_e;

  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] sync1_q, sync_q;
  logic [NumBtn-1:0] level_q, level_d;
  logic [NumBtn-1:0] press_q, press_d;
  logic [NumBtn-1:0] release_q, release_d;
  logic [NumBtn-1:0][DbW-1:0] db_cnt_q, db_cnt_d;

  rpt_state_e        state_q [NumRpt];
  rpt_state_e        state_d [NumRpt];
  logic [RptW-1:0]   rpt_cnt_q [NumRpt];
  logic [RptW-1:0]   rpt_cnt_d [NumRpt];
  logic [NumRpt-1:0] repeat_q, repeat_d;

  assign raw = {btnR, btnL, btnD, btnU, btnC};

  // Two-flop synchronizer per button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync_q  <= sync1_q;
    end
  end

  // Debounce: a level change is accepted only after sync disagrees with level for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    db_cnt_d  = db_cnt_q;
    for (int i = 0; i < NumBtn; i++) begin
      if (sync_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbLast) begin
        db_cnt_d[i]  = '0;
        level_d[i]   = sync_q[i];
        press_d[i]   = sync_q[i];
        release_d[i] = ~sync_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // Auto-repeat for U (button 1) and D (button 2). The FSM reacts to the same
  // event that raises press, so it sits in StDelay with count 0 in the press cycle.
  always_comb begin
    repeat_d = '0;
    for (int c = 0; c < NumRpt; c++) begin
      state_d[c]   = state_q[c];
      rpt_cnt_d[c] = rpt_cnt_q[c];
      unique case (state_q[c])
        StIdle: begin
          if (press_d[c+1]) begin
            state_d[c]   = StDelay;
            rpt_cnt_d[c] = '0;
          end
        end
        StDelay: begin
          if (release_d[c+1]) begin
            state_d[c]   = StIdle;
            rpt_cnt_d[c] = '0;
          end else if (rpt_cnt_q[c] == DelayLast) begin
            state_d[c]   = StRepeat;
            rpt_cnt_d[c] = '0;
            repeat_d[c]  = 1'b1;
          end else begin
            rpt_cnt_d[c] = rpt_cnt_q[c] + 1'b1;
          end
        end
        StRepeat: begin
          if (release_d[c+1]) begin
            state_d[c]   = StIdle;
            rpt_cnt_d[c] = '0;
          end else if (rpt_cnt_q[c] == PeriodLast) begin
            rpt_cnt_d[c] = '0;
            repeat_d[c]  = 1'b1;
          end else begin
            rpt_cnt_d[c] = rpt_cnt_q[c] + 1'b1;
          end
        end
        default: begin
          state_d[c]   = StIdle;
          rpt_cnt_d[c] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NumRpt; c++) begin
        state_q[c]   <= StIdle;
        rpt_cnt_q[c] <= '0;
      end
      repeat_q <= '0;
    end else begin
      for (int c = 0; c < NumRpt; c++) begin
        state_q[c]   <= state_d[c];
        rpt_cnt_q[c] <= rpt_cnt_d[c];
      end
      repeat_q <= repeat_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timings.
// A cycle table covers glitch, bounce and simultaneous presses; sequences cover repeat and reset.
module tb_button_conditioner;

  localparam int unsigned Db     = 4;
  localparam int unsigned Delay  = 10;
  localparam int unsigned Period = 3;

  localparam logic [4:0] BN = 5'b00000;
  localparam logic [4:0] BC = 5'b00001;
  localparam logic [4:0] BL = 5'b01000;
  localparam logic [4:0] BR = 5'b10000;
  localparam logic [4:0] BCD = 5'b00101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btnC = 1'b0, btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0;
  logic [4:0] level, press, release_pulse;
  logic [1:0] repeat_pulse;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0] btn;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rls;
  } vec_t;

  vec_t vecs[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_DELAY   (Delay),
    .REPEAT_PERIOD  (Period)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btnC         (btnC),
    .btnU         (btnU),
    .btnD         (btnD),
    .btnL         (btnL),
    .btnR         (btnR),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int idx, input logic [4:0] got,
                       input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %b, expected %b", name, idx, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input int n, input logic [4:0] b, input logic [4:0] l,
                     input logic [4:0] p, input logic [4:0] r);
    vec_t v;
    v.btn = b;
    v.lvl = l;
    v.prs = p;
    v.rls = r;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns once press[bit_i] is seen; a missing pulse is a failed comparison.
  task automatic wait_press(input int bit_i, input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (press[bit_i]) begin
        ok = 1;
        break;
      end
    end
    check_int(name, ok, 1);
  endtask

  initial begin
    int first;
    int npress;

    // Glitch on R: three cycles high never reaches four stable synced cycles.
    add(3, BR, BN, BN, BN);
    add(7, BN, BN, BN, BN);
    // Bounce on L, then a steady high sampled from row 18; pulse five rows later.
    add(2, BL, BN, BN, BN);
    add(2, BN, BN, BN, BN);
    add(2, BL, BN, BN, BN);
    add(2, BN, BN, BN, BN);
    add(5, BL, BN, BN, BN);
    add(1, BL, BL, BL, BN);
    add(2, BL, BL, BN, BN);
    add(5, BN, BL, BN, BN);
    add(1, BN, BN, BN, BL);
    add(2, BN, BN, BN, BN);
    // C and D together; D is released before its first repeat would fire.
    add(5, BCD, BN, BN, BN);
    add(1, BCD, BCD, BCD, BN);
    add(2, BCD, BCD, BN, BN);
    add(5, BN, BCD, BN, BN);
    add(1, BN, BN, BN, BCD);
    add(2, BN, BN, BN, BN);

    #12;
    check("reset_level", 0, level, BN);
    check("reset_press", 0, press | release_pulse | {3'b000, repeat_pulse}, BN);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    foreach (vecs[i]) begin
      {btnR, btnL, btnD, btnU, btnC} = vecs[i].btn;
      step();
      check("tbl_level", i, level, vecs[i].lvl);
      check("tbl_press", i, press, vecs[i].prs);
      check("tbl_release", i, release_pulse, vecs[i].rls);
      check("tbl_repeat", i, {3'b000, repeat_pulse}, BN);
    end

    // Auto-repeat on U; release pulse lands on offset 25, where a repeat is suppressed.
    btnU = 1'b1;
    wait_press(1, "rpt_u_press");
    for (int off = 1; off <= 40; off++) begin
      if (off == 20) btnU = 1'b0;
      step();
      check("rpt_u_repeat", off, {4'b0000, repeat_pulse[0]},
            {4'b0000, (off == 10 || off == 13 || off == 16 || off == 19 || off == 22)});
      check("rpt_u_release", off, {4'b0000, release_pulse[1]}, {4'b0000, off == 25});
      check("rpt_u_press_once", off, {4'b0000, press[1]}, 5'b00000);
    end

    // D released during the delay window: no repeat, then a fresh full delay.
    btnD = 1'b1;
    wait_press(2, "dly_d_press");
    for (int off = 1; off <= 30; off++) begin
      if (off == 1) btnD = 1'b0;
      step();
      check("dly_d_repeat", off, {4'b0000, repeat_pulse[1]}, 5'b00000);
      check("dly_d_release", off, {4'b0000, release_pulse[2]}, {4'b0000, off == 6});
    end
    btnD = 1'b1;
    wait_press(2, "dly_d_press2");
    for (int off = 1; off <= 12; off++) begin
      step();
      check("dly_d_repeat2", off, {4'b0000, repeat_pulse[1]}, {4'b0000, off == 10});
    end
    btnD = 1'b0;
    repeat (12) step();

    // Reset mid-cycle while C is held, then C seen as a fresh press after reset.
    btnC = 1'b1;
    wait_press(0, "rst_c_press");
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_level", 0, level, BN);
    check("rst_async_pulses", 0, press | release_pulse | {3'b000, repeat_pulse}, BN);
    step();
    check("rst_hold_level", 1, level, BN);
    @(negedge clk);
    rst_n = 1'b1;
    first  = 0;
    npress = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (press[0]) begin
        npress++;
        if (first == 0) first = i;
      end
      check("rst_exit_release", i, release_pulse, BN);
    end
    check_int("rst_press_edge", first, 6);
    check_int("rst_press_count", npress, 1);
    check("rst_level_after", 0, level, BC);
    btnC = 1'b0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
